// File: rtl/fetch_queue_if.sv
// Bundle of the fetch queue's signals: the redirect input, the instruction-memory request/response
// channel and the decoder dequeue port. The master modport is the fetch queue's view; the slave
// modport is the view of the environment (memory model plus decoder).
interface fetch_queue_if;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_valid;
  logic        imem_ready;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        deq_valid;
  logic        deq_ready;
  logic [31:0] deq_instr;
  logic [31:0] deq_pc;

  modport master (
    input  redirect, redirect_pc, imem_ready, imem_rvalid, imem_rdata, deq_ready,
    output imem_valid, imem_addr, deq_valid, deq_instr, deq_pc
  );

  modport slave (
    output redirect, redirect_pc, imem_ready, imem_rvalid, imem_rdata, deq_ready,
    input  imem_valid, imem_addr, deq_valid, deq_instr, deq_pc
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: it issues in-order word fetches under a credit limit and buffers the
// responses for the decoder. Responses to requests made before a redirect are dropped.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic          clock,
  input logic          reset,
  fetch_queue_if.master bus
);

  localparam int          PTR_W = $clog2(DEPTH);
  localparam int          CNT_W = PTR_W + 1;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] discard_q, discard_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]      instr_mem_q [DEPTH];
  logic [31:0]      pc_mem_q    [DEPTH];

  logic [CNT_W:0]   used;
  logic [31:0]      redirect_target;
  logic             credit_ok;
  logic             req_fire;
  logic             resp_keep;
  logic             resp_drop;
  logic             deq_fire;
  logic             mem_we;

  // Credits cover both buffered entries and every in-flight request, including ones that will be discarded.
  always_comb begin
    used            = {1'b0, count_q} + {1'b0, outstanding_q};
    credit_ok       = used < (CNT_W + 1)'(DEPTH);
    redirect_target = bus.redirect_pc & 32'hFFFF_FFFC;

    bus.imem_valid  = reset && !bus.redirect && credit_ok;
    bus.imem_addr   = fetch_pc_q;
    req_fire        = bus.imem_valid && bus.imem_ready;

    resp_keep       = bus.imem_rvalid && (discard_q == '0);
    resp_drop       = bus.imem_rvalid && (discard_q != '0);
    mem_we          = resp_keep && !bus.redirect;

    bus.deq_valid   = (count_q != '0);
    deq_fire        = bus.deq_valid && bus.deq_ready && !bus.redirect;
    bus.deq_instr   = bus.deq_valid ? instr_mem_q[rd_ptr_q] : NOP;
    bus.deq_pc      = bus.deq_valid ? pc_mem_q[rd_ptr_q] : 32'h0000_0000;
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    count_d       = count_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;

    if (bus.redirect) begin
      // Every request still in flight after this cycle belongs to the old stream.
      fetch_pc_d    = redirect_target;
      resp_pc_d     = redirect_target;
      count_d       = '0;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      outstanding_d = outstanding_q - CNT_W'(bus.imem_rvalid);
      discard_d     = outstanding_q - CNT_W'(bus.imem_rvalid);
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(bus.imem_rvalid);
      if (resp_drop) begin
        discard_d = discard_q - CNT_W'(1);
      end
      if (resp_keep) begin
        wr_ptr_d  = wr_ptr_q + PTR_W'(1);
        resp_pc_d = resp_pc_q + 32'd4;
      end
      if (deq_fire) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(resp_keep) - CNT_W'(deq_fire);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      count_q       <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  // Storage needs no reset: an entry is only read once the count says it was written.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      instr_mem_q[wr_ptr_q] <= bus.imem_rdata;
      pc_mem_q[wr_ptr_q]    <= resp_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: an in-order memory model with variable latency plus an
// expected-instruction scoreboard derived from the in-order fetch and redirect rules.
module tb_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;

  fetch_queue_if bus();

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clock = ~clock;

  req_t        mem_q[$];
  exp_t        exp_q[$];
  int          fresh;
  int          epoch;
  int          cyc;
  int          vectors;
  int          miscompares;
  int          acc_cnt;
  int          deq_cnt;
  int          lat_min;
  int          lat_max;
  int          visible;
  int          base;
  bit          resp_now;
  bit          exp_valid;
  logic [31:0] model_fetch_pc;
  logic [31:0] model_resp_pc;

  // Memory contents are a fixed scramble of the address so every word is distinguishable.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[23:0], a[31:24]} ^ 32'hC3A5_5A3C;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(posedge clock) cyc++;

  // Monitor: samples the DUT just after the falling edge, checks against the model, and records
  // the handshakes that will complete on the next rising edge.
  always @(negedge clock) begin
    #1;
    if (!reset) begin
      checkOutput("rst_imem_valid", {31'b0, bus.imem_valid}, 32'd0);
      checkOutput("rst_deq_valid", {31'b0, bus.deq_valid}, 32'd0);
      checkOutput("rst_deq_instr", bus.deq_instr, NOP);
      checkOutput("rst_deq_pc", bus.deq_pc, 32'd0);
      checkOutput("rst_imem_addr", bus.imem_addr, RESET_PC);
    end else begin
      visible   = exp_q.size() - fresh;
      exp_valid = !bus.redirect && ((visible + mem_q.size() + int'(resp_now)) < DEPTH);
      checkOutput("imem_valid", {31'b0, bus.imem_valid}, {31'b0, exp_valid});
      if (bus.imem_valid) begin
        checkOutput("imem_addr", bus.imem_addr, model_fetch_pc);
      end
      if (bus.imem_valid && bus.imem_ready) begin
        mem_q.push_back('{bus.imem_addr, epoch, cyc + $urandom_range(lat_max, lat_min)});
        model_fetch_pc = model_fetch_pc + 32'd4;
        acc_cnt++;
      end
      checkOutput("deq_valid", {31'b0, bus.deq_valid}, {31'b0, visible != 0});
      if (visible != 0) begin
        checkOutput("deq_pc", bus.deq_pc, exp_q[0].pc);
        checkOutput("deq_instr", bus.deq_instr, exp_q[0].instr);
        if (bus.deq_ready && !bus.redirect) begin
          void'(exp_q.pop_front());
          deq_cnt++;
        end
      end else begin
        checkOutput("idle_deq_instr", bus.deq_instr, NOP);
        checkOutput("idle_deq_pc", bus.deq_pc, 32'd0);
      end
      if (bus.redirect) begin
        exp_q.delete();
      end
      fresh = 0;
    end
  end

  // One cycle of stimulus; the memory model answers in order once a request's latency has elapsed.
  task automatic applyStimulus(input bit redir, input logic [31:0] rpc, input bit dready, input bit iready);
    req_t r;
    @(negedge clock);
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
    bus.deq_ready   = dready;
    bus.imem_ready  = iready;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = $urandom;
    resp_now        = 1'b0;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      r               = mem_q.pop_front();
      resp_now        = 1'b1;
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = mem_word(r.addr);
      if (r.epoch == epoch && !redir) begin
        exp_q.push_back('{model_resp_pc, mem_word(model_resp_pc)});
        model_resp_pc = model_resp_pc + 32'd4;
        fresh         = 1;
      end
    end
    if (redir) begin
      epoch++;
      model_fetch_pc = rpc & 32'hFFFF_FFFC;
      model_resp_pc  = rpc & 32'hFFFF_FFFC;
    end
  endtask

  // Holds reset for n cycles; the release cycle drives the given ready levels with no response.
  task automatic doReset(input int n, input bit dready, input bit iready);
    @(negedge clock);
    reset           = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'd0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'd0;
    bus.deq_ready   = 1'b0;
    bus.imem_ready  = 1'b0;
    resp_now        = 1'b0;
    fresh           = 0;
    mem_q.delete();
    exp_q.delete();
    epoch++;
    model_fetch_pc  = RESET_PC;
    model_resp_pc   = RESET_PC;
    repeat (n) @(negedge clock);
    bus.deq_ready   = dready;
    bus.imem_ready  = iready;
    reset           = 1'b1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    epoch       = 0;
    fresh       = 0;
    acc_cnt     = 0;
    deq_cnt     = 0;
    lat_min     = 1;
    lat_max     = 1;

    // Back-to-back streaming at latency 1 must sustain one dequeue per cycle.
    doReset(3, 1'b1, 1'b1);
    repeat (10) applyStimulus(1'b0, 32'd0, 1'b1, 1'b1);
    base = deq_cnt;
    repeat (20) applyStimulus(1'b0, 32'd0, 1'b1, 1'b1);
    checkOutput("stream_rate", deq_cnt - base, 32'd20);

    // Decoder stalled: exactly DEPTH requests go out, then the queue drains in order.
    doReset(2, 1'b0, 1'b0);
    base = acc_cnt;
    repeat (12) applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
    checkOutput("stall_accepts", acc_cnt - base, DEPTH);
    repeat (10) applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);

    // Memory back-pressure with the request held, then a redirect over two slow requests.
    lat_min = 3;
    lat_max = 3;
    repeat (3) applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    repeat (2) applyStimulus(1'b0, 32'd0, 1'b1, 1'b1);
    applyStimulus(1'b1, 32'h0000_0102, 1'b1, 1'b0);
    repeat (12) applyStimulus(1'b0, 32'd0, 1'b1, 1'b1);

    // Redirect landing together with a response and a dequeue, then address wrap-around.
    lat_min = 1;
    lat_max = 1;
    repeat (6) applyStimulus(1'b0, 32'd0, 1'b1, 1'b1);
    applyStimulus(1'b1, 32'h0000_2000, 1'b1, 1'b1);
    repeat (4) applyStimulus(1'b0, 32'd0, 1'b1, 1'b1);
    applyStimulus(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1);
    repeat (12) applyStimulus(1'b0, 32'd0, 1'b1, 1'b1);

    // Random traffic with variable latency, random redirects and a reset in the middle.
    lat_min = 1;
    lat_max = 4;
    for (int i = 0; i < 1500; i++) begin
      applyStimulus($urandom_range(99) < 3, $urandom, $urandom_range(99) < 70, $urandom_range(99) < 75);
    end
    doReset(2, 1'b1, 1'b1);
    for (int i = 0; i < 1500; i++) begin
      applyStimulus($urandom_range(99) < 3, $urandom, $urandom_range(99) < 70, $urandom_range(99) < 75);
    end
    repeat (20) applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);

    @(negedge clock);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; power of two, >=2.
REQ-002 Parameter RESET_PC, default 32'h00000000, first fetch address after reset.
REQ-003 clock  input  1  single clock, all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 redirect  input  1  flush queue and restart fetch at redirect_pc.
REQ-006 redirect_pc  input  32  new fetch address.
REQ-007 imem_valid  output  1  fetch request valid.
REQ-008 imem_ready  input  1  memory accepts request.
REQ-009 imem_addr  output  32  fetch address, word aligned.
REQ-010 imem_rvalid  input  1  response valid; responses in request order, exactly one per accepted request, latency >=1 cycle.
REQ-011 imem_rdata  input  32  fetched instruction word.
REQ-012 deq_valid  output  1  instruction available to decoder.
REQ-013 deq_ready  input  1  decoder consumes head entry.
REQ-014 deq_instr  output  32  head instruction, presented to decoder instr input.
REQ-015 deq_pc  output  32  address of head instruction.

Function
REQ-016 Request accepted when imem_valid and imem_ready high in same cycle; fetch pc then advances by 4 (mod 2^32, wraps silently).
REQ-017 Credit rule: imem_valid = !redirect and (count + outstanding) < DEPTH; queue therefore never overflows.
REQ-018 outstanding counter: +1 on accepted request, -1 on any imem_rvalid; both in same cycle leaves it unchanged; width log2(DEPTH)+1.
REQ-019 imem_addr held stable while imem_valid high and imem_ready low.
REQ-020 Response with discard==0: {imem_rdata, pc of its request} written at tail; visible at deq one cycle later (no bypass).
REQ-021 Per-entry pc tracked by a response-pc counter advancing by 4 per kept response, reloaded on redirect.
REQ-022 Dequeue occurs when deq_valid and deq_ready; head advances; deq_valid = (count != 0).
REQ-023 Enqueue and dequeue in same cycle: count unchanged, both pointers advance; legal at full and at count==1.
REQ-024 deq_ready with deq_valid low: no effect.
REQ-025 When deq_valid low, deq_instr = 32'h00000013 (nop) and deq_pc = 0.
REQ-026 Redirect (highest priority): count<=0, pointers<=0, fetch pc and response pc <= {redirect_pc[31:2],2'b00}; dequeue that cycle ignored.
REQ-027 On redirect, discard <= outstanding - imem_rvalid; no request issued in redirect cycle.
REQ-028 Response while discard>0: dropped, discard decrements; not counted against queue.
REQ-029 Redirect while discard>0: discard recomputed per REQ-027 (stale responses never enter queue).
REQ-030 Credit rule in REQ-017 counts discarded outstanding requests, so a redirect never causes overflow.
REQ-031 No combinational path from imem_rvalid/imem_rdata to deq outputs.

Reset
REQ-032 reset low: fetch pc and response pc = RESET_PC, count=0, outstanding=0, discard=0, pointers=0, immediately (asynchronous).
REQ-033 During reset: imem_valid=0, deq_valid=0, deq_instr=32'h00000013, deq_pc=0, imem_addr=RESET_PC.
REQ-034 First request issued on first rising edge after reset deasserts; reset mid-operation discards all queued data and in-flight responses are treated as not outstanding (environment also resets memory).

Verification
REQ-035 Reset, imem_ready=1, latency 1, deq_ready=1 -> addresses 0,4,8,... issued back to back; deq_pc sequence 0,4,8 with matching data, one per cycle in steady state.
REQ-036 deq_ready=0, DEPTH=4 -> exactly 4 requests accepted, imem_valid then low; count stays 4; releasing deq_ready drains in order 0,4,8,12.
REQ-037 imem_ready low 3 cycles with imem_valid high -> imem_addr constant; no pc advance.
REQ-038 Two requests outstanding (latency 3), redirect to 32'h00000102 -> both late responses dropped, next request address 32'h00000100, deq_pc first 32'h00000100.
REQ-039 Redirect in same cycle as a response and a dequeue -> queue empty next cycle, discard = outstanding-1, deq_valid=0, deq_instr=32'h00000013.
REQ-040 Fetch at 32'hFFFFFFFC -> next address 32'h00000000, no error.
